// File: rtl/link_pkg.sv
// Shared definitions for the byte link (slave and master sides).
//   link_state_e   : slave handshake state enumeration
//   BYTES_PER_WORD : bytes assembled into one word
//   BYTE_W/WORD_W  : byte and word widths
//   IDX_W          : width of the byte slot index
package link_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACK_HI    = 2'd1,
    ST_WORD_OUT  = 2'd2,
    ST_ERR_DRAIN = 2'd3
  } link_state_e;

endpackage

// File: rtl/link_timeout_ctr.sv
// Handshake timeout counter.
//   clk       : clock
//   rst       : asynchronous active-high reset
//   i_clear   : restart the count at zero
//   i_enable  : count one cycle of waiting
//   o_expired : high in the enabled cycle whose increment reaches TIMEOUT
// TIMEOUT = 0 disables expiry entirely.
module link_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int            CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST  = LIMIT - CW'(1);
  localparam bit            TO_EN = (TIMEOUT != 0);

  logic [CW-1:0] r_cnt;

  // Expiry is flagged combinationally so the FSM can react on the same edge
  // that would carry the count to TIMEOUT.
  assign o_expired = TO_EN && i_enable && (r_cnt == LAST);

  // Saturates at LIMIT so a long drain never wraps back into range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/slave_fsm.sv
// 4-phase link slave: collects four bytes into a 32-bit word.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req        : request from link master, data valid while high
//   data       : byte from master, captured when req is seen in IDLE
//   word_ready : downstream accepts the held word
//   ack        : registered acknowledge to master
//   word       : assembled word, byte 0 in [7:0]
//   word_valid : word is being held for the consumer
//   err        : one-cycle pulse when ack waited TIMEOUT cycles for req to fall
module slave_fsm
  import link_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [BYTE_W-1:0] data,
  input  logic              word_ready,
  output logic              ack,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic              err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  link_state_e                           r_state;
  logic [IDX_W-1:0]                      r_idx;
  logic [BYTES_PER_WORD-1:0][BYTE_W-1:0] r_slots;
  logic [WORD_W-1:0]                     r_word;
  logic                                  r_ack;
  logic                                  r_word_valid;
  logic                                  r_err;

  logic w_clear;
  logic w_enable;
  logic w_expired;

  // Count restarts at each capture and advances only while ack waits on req.
  assign w_clear  = (r_state == ST_IDLE) && req;
  assign w_enable = (r_state == ST_ACK_HI) && req;

  link_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_enable (w_enable),
    .o_expired(w_expired)
  );

  assign ack        = r_ack;
  assign word       = r_word;
  assign word_valid = r_word_valid;
  assign err        = r_err;

  // ack and word_valid are updated together with the state so they are
  // exact registered decodes of ACK_HI and WORD_OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= '0;
      r_slots      <= '0;
      r_word       <= '0;
      r_ack        <= 1'b0;
      r_word_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_slots[r_idx] <= data;
            r_ack          <= 1'b1;
            r_state        <= ST_ACK_HI;
          end
        end
        ST_ACK_HI: begin
          if (!req) begin
            r_ack <= 1'b0;
            if (r_idx == LAST_IDX) begin
              // Word is published only here, so partial words never show.
              r_word       <= r_slots;
              r_word_valid <= 1'b1;
              r_state      <= ST_WORD_OUT;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= ST_IDLE;
            end
          end else if (w_expired) begin
            r_err   <= 1'b1;
            r_ack   <= 1'b0;
            r_idx   <= '0;
            r_slots <= '0;
            r_state <= ST_ERR_DRAIN;
          end
        end
        ST_WORD_OUT: begin
          // req is deliberately not looked at here; a still-high req is
          // picked up by IDLE on the following edge.
          if (word_ready) begin
            r_word_valid <= 1'b0;
            r_idx        <= '0;
            r_state      <= ST_IDLE;
          end
        end
        ST_ERR_DRAIN: begin
          // Wait for req to drop so the stale byte is not captured again.
          if (!req) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ack        <= 1'b0;
          r_word_valid <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_fsm.sv
module tb_slave_fsm;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        req        = 1'b0;
  logic [7:0]  data       = 8'h00;
  logic        word_ready = 1'b1;

  logic        ack_a, wv_a, err_a;
  logic [31:0] word_a;
  logic        ack_b, wv_b, err_b;
  logic [31:0] word_b;

  always #5 clk = ~clk;

  slave_fsm #(.TIMEOUT(255)) u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .word_ready(word_ready),
    .ack       (ack_a),
    .word      (word_a),
    .word_valid(wv_a),
    .err       (err_a)
  );

  slave_fsm #(.TIMEOUT(0)) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .word_ready(word_ready),
    .ack       (ack_b),
    .word      (word_b),
    .word_valid(wv_b),
    .err       (err_b)
  );

  int checks = 0;
  int errors = 0;
  bit rand_mode = 1'b0;

  // Monitor counters, written only by the compare process.
  int   ncyc       = 0;
  int   ack_rise_a = 0;
  int   wv_cyc_a   = 0;
  int   err_cnt_a  = 0;
  int   err_cnt_b  = 0;
  int   t_ack_a    = 0;
  int   t_err_a    = 0;
  logic prev_ack_a = 1'b0;

  // Reference model: index 0 = TIMEOUT 255 instance, index 1 = TIMEOUT 0.
  int          to_val  [2] = '{255, 0};
  bit          m_ack   [2] = '{1'b0, 1'b0};
  bit          m_wv    [2] = '{1'b0, 1'b0};
  bit          m_err   [2] = '{1'b0, 1'b0};
  bit          m_drain [2] = '{1'b0, 1'b0};
  int          m_cnt   [2] = '{0, 0};
  int          m_held  [2] = '{0, 0};
  logic [31:0] m_acc   [2] = '{32'h0, 32'h0};
  logic [31:0] m_word  [2] = '{32'h0, 32'h0};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: bytes are accumulated arithmetically; a word is published when
  // the fourth acknowledged byte is released.
  initial begin : model
    bit          a, v, d, e;
    int          n, h;
    logic [31:0] acc, w;
    forever begin
      @(posedge clk or posedge rst);
      for (int k = 0; k < 2; k++) begin
        if (rst) begin
          m_ack[k] = 1'b0; m_wv[k] = 1'b0; m_err[k] = 1'b0; m_drain[k] = 1'b0;
          m_cnt[k] = 0; m_held[k] = 0; m_acc[k] = 32'h0; m_word[k] = 32'h0;
        end else begin
          a = m_ack[k]; v = m_wv[k]; d = m_drain[k];
          n = m_cnt[k]; h = m_held[k]; acc = m_acc[k]; w = m_word[k];
          e = 1'b0;
          if (v) begin
            if (word_ready) v = 1'b0;
          end else if (d) begin
            if (!req) d = 1'b0;
          end else if (!a) begin
            if (req) begin
              acc = acc | (32'(data) << (8 * n));
              n = n + 1; a = 1'b1; h = 0;
            end
          end else if (!req) begin
            a = 1'b0;
            if (n == 4) begin
              w = acc; v = 1'b1; acc = 32'h0; n = 0;
            end
          end else begin
            h = h + 1;
            if (to_val[k] != 0 && h == to_val[k]) begin
              e = 1'b1; a = 1'b0; d = 1'b1; acc = 32'h0; n = 0;
            end
          end
          m_ack[k] = a; m_wv[k] = v; m_err[k] = e; m_drain[k] = d;
          m_cnt[k] = n; m_held[k] = h; m_acc[k] = acc; m_word[k] = w;
        end
      end
    end
  end

  // Compare every cycle on the falling edge, plus event monitors.
  initial begin : compare
    forever begin
      @(negedge clk);
      ncyc++;
      check("ack_a",  32'(ack_a), 32'(m_ack[0]));
      check("wv_a",   32'(wv_a),  32'(m_wv[0]));
      check("err_a",  32'(err_a), 32'(m_err[0]));
      check("word_a", word_a,     m_word[0]);
      check("ack_b",  32'(ack_b), 32'(m_ack[1]));
      check("wv_b",   32'(wv_b),  32'(m_wv[1]));
      check("err_b",  32'(err_b), 32'(m_err[1]));
      check("word_b", word_b,     m_word[1]);
      if (ack_a && !prev_ack_a) begin
        ack_rise_a++;
        t_ack_a = ncyc;
      end
      prev_ack_a = ack_a;
      if (wv_a) wv_cyc_a++;
      if (err_a) begin
        err_cnt_a++;
        t_err_a = ncyc;
      end
      if (err_b) err_cnt_b++;
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
    if (rand_mode) word_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ack(input logic v, input int budget, input string nm);
    int i;
    i = 0;
    while (ack_a !== v && i < budget) begin
      tick();
      i++;
    end
    if (ack_a !== v) check(nm, 32'(ack_a), 32'(v));
  endtask

  task automatic raise(input logic [7:0] b);
    req  = 1'b1;
    data = b;
    wait_ack(1'b1, 3000, "ack_rise_bound");
  endtask

  task automatic finish(input int hold);
    repeat (hold) tick();
    req  = 1'b0;
    data = 8'($urandom);
    tick();
    wait_ack(1'b0, 50, "ack_fall_bound");
  endtask

  task automatic send(input logic [7:0] b, input int hold);
    raise(b);
    finish(hold);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin : main
    int s_ack, s_wv, s_err_a, s_err_b, r, hold;

    // Reset state
    repeat (3) tick();
    check("rst_ack_a",  32'(ack_a), 32'd0);
    check("rst_wv_a",   32'(wv_a),  32'd0);
    check("rst_err_a",  32'(err_a), 32'd0);
    check("rst_word_a", word_a,     32'h0);
    check("rst_ack_b",  32'(ack_b), 32'd0);
    rst = 1'b0;
    tick();

    // Basic word with consumer always ready
    s_ack = ack_rise_a; s_wv = wv_cyc_a;
    send(8'h11, 0); send(8'h22, 1); send(8'h33, 2); send(8'h44, 0);
    repeat (3) tick();
    check("t1_word_a",     word_a, 32'h44332211);
    check("t1_word_b",     word_b, 32'h44332211);
    check("t1_wv_cycles",  32'(wv_cyc_a - s_wv), 32'd1);
    check("t1_ack_pulses", 32'(ack_rise_a - s_ack), 32'd4);

    // Consumer stalls for 10 cycles; req activity during WORD_OUT
    word_ready = 1'b0;
    s_ack = ack_rise_a; s_wv = wv_cyc_a;
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    check("t2_wv_up", 32'(wv_a), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 3) begin req = 1'b1; data = 8'h99; end
      if (i == 6) req = 1'b0;
      if (i == 9) begin req = 1'b1; data = 8'h5A; end
    end
    word_ready = 1'b1;
    wait_ack(1'b1, 10, "t2_ack_after_exit");
    check("t2_wv_cycles",  32'(wv_cyc_a - s_wv), 32'd11);
    check("t2_ack_pulses", 32'(ack_rise_a - s_ack), 32'd5);
    check("t2_word_a",     word_a, 32'h44332211);
    finish(0);
    send(8'h5B, 0); send(8'h5C, 0); send(8'h5D, 0);
    repeat (3) tick();
    check("t2_word2_a", word_a, 32'h5D5C5B5A);
    check("t2_word2_b", word_b, 32'h5D5C5B5A);

    // Timeout with TIMEOUT=255, then recovery
    pulse_reset();
    s_err_a = err_cnt_a; s_err_b = err_cnt_b; s_wv = wv_cyc_a;
    raise(8'h77);
    repeat (300) tick();
    check("t3_err_delay",    32'(t_err_a - t_ack_a), 32'd255);
    check("t3_err_pulses_a", 32'(err_cnt_a - s_err_a), 32'd1);
    check("t3_ack_a_low",    32'(ack_a), 32'd0);
    check("t3_ack_b_high",   32'(ack_b), 32'd1);
    check("t3_err_pulses_b", 32'(err_cnt_b - s_err_b), 32'd0);
    check("t3_no_word",      32'(wv_cyc_a - s_wv), 32'd0);
    finish(0);
    send(8'hA0, 0); send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 0);
    repeat (3) tick();
    check("t3_word_a", word_a, 32'hA3A2A1A0);
    check("t3_word_b", word_b, 32'hA2A1A077);

    // Timeout disabled: req held for 1000 cycles
    pulse_reset();
    s_err_b = err_cnt_b;
    raise(8'h5A);
    repeat (1000) tick();
    check("t5_ack_b_high",   32'(ack_b), 32'd1);
    check("t5_err_pulses_b", 32'(err_cnt_b - s_err_b), 32'd0);
    finish(0);
    send(8'h61, 0); send(8'h62, 0); send(8'h63, 0);
    repeat (3) tick();
    check("t5_word_b", word_b, 32'h6362615A);
    check("t5_word_a", word_a, 32'h0);

    // Reset in the middle of a word
    pulse_reset();
    send(8'h10, 0);
    raise(8'h20);
    rst = 1'b1;
    #1;
    check("t4_ack_a_async", 32'(ack_a), 32'd0);
    check("t4_ack_b_async", 32'(ack_b), 32'd0);
    req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("t4_word_cleared", word_a, 32'h0);
    s_wv = wv_cyc_a;
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    repeat (3) tick();
    check("t4_word_a",    word_a, 32'h04030201);
    check("t4_wv_cycles", 32'(wv_cyc_a - s_wv), 32'd1);

    // Randomized traffic against the model
    pulse_reset();
    rand_mode = 1'b1;
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        pulse_reset();
      end else if (r < 13) begin
        req  = 1'b1;
        data = 8'($urandom);
        tick();
        req = 1'b0;
        tick();
        wait_ack(1'b0, 50, "glitch_ack_fall_bound");
      end else begin
        hold = ($urandom_range(0, 24) == 0) ? 260 : $urandom_range(0, 4);
        send(8'($urandom), hold);
      end
    end
    rand_mode  = 1'b0;
    word_ready = 1'b1;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
